sboxaesinv_seq: RTL and testbench

Sequential AES inverse S-box (InvSubBytes for one byte). Each accepted byte goes through the inverse affine transform and is then inverted in GF(2^8) (modulus 0x11B) by iterative exponentiation to x^254, one field operation per clock. It sits on the decryption side of the byte-serial AES datapath, opposite the forward S-box. Throughput is traded for area: one shared GF(2^8) multiplier, no 256-entry table. Valid/ready handshakes on both sides.

---
 rtl/sboxaesinv_seq.sv | 108 ++++++++++
 tb/tb_sboxaesinv_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sboxaesinv_seq.sv
// rtl/sboxaesinv_seq.sv - sequential AES inverse S-box using one shared GF(2^8) multiplier
// Inverse affine on entry, then x^254 by square-and-multiply, one field op per clock.
module sboxaesinv_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, SQ, MUL, OUT} state_e;

  state_e     state_q, state_d;
  logic [7:0] t_q, t_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [7:0] affine;
  logic [7:0] mul_b;
  logic [7:0] prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  assign affine = {in[6:0], in[7]} ^ {in[4:0], in[7:5]} ^ {in[1:0], in[7:2]} ^ 8'h05;

  // Squaring reuses the multiplier with acc on both operands.
  assign mul_b = (state_q == SQ) ? acc_q : t_q;
  assign prod  = gf_mul(acc_q, mul_b);

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          t_d     = affine;
          acc_d   = affine;
          cnt_d   = 3'd6;
          state_d = SQ;
        end
      end
      SQ: begin
        acc_d = prod;
        if (cnt_q == 3'd0) begin
          out_d       = prod;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d   = prod;
        cnt_d   = cnt_q - 3'd1;
        state_d = SQ;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= 8'h00;
      acc_q       <= 8'h00;
      cnt_q       <= 3'd0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_sboxaesinv_seq.sv
// tb/tb_sboxaesinv_seq.sv - self-checking bench for sboxaesinv_seq
// Inputs driven and outputs sampled on the falling edge.
module tb_sboxaesinv_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out;
  logic       out_ready;

  sboxaesinv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready)
  );

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    return SBOX_FLAT[2047 - 8*int'(x) -: 8];
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [5];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_hs  = 0;
  int acc_cyc [$];
  logic [7:0] outs [$];
  bit seen53 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
    if (rst_n && out_valid && out_ready) begin
      n_hs++;
      outs.push_back(out);
    end
    if (out_valid && out == 8'h53) seen53 = 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge with in_ready high; returns result and accept-to-out_valid latency.
  task automatic run_byte(input logic [7:0] b, input bit consume,
                          output logic [7:0] r, output int lat);
    in       = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = out;
    if (consume) @(negedge clk);
  endtask

  logic [7:0] r;
  int lat;
  int bad_lat;
  int bad_inv;
  int hs0;
  int acc0;
  int err_cnt;
  logic [7:0] b2b_in [4];
  logic [7:0] b2b_exp [4];

  initial begin
    vecs[0] = '{din: 8'h63, dout: 8'h00};
    vecs[1] = '{din: 8'h7c, dout: 8'h01};
    vecs[2] = '{din: 8'h00, dout: 8'h52};
    vecs[3] = '{din: 8'h16, dout: 8'hff};
    vecs[4] = '{din: 8'hed, dout: 8'h53};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in        = 8'h00;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out", out, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known vectors with out_ready high
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      run_byte(vecs[i].din, 1'b1, r, lat);
      chk($sformatf("vec%0d_out", i), r, vecs[i].dout);
      chk($sformatf("vec%0d_latency", i), lat, 13);
      chk($sformatf("vec%0d_idle_after", i), {in_ready, out_valid}, 2'b10);
    end

    // Backpressure: result must hold, second pulse ignored
    out_ready = 1'b0;
    hs0  = n_hs;
    run_byte(8'h16, 1'b0, r, lat);
    acc0 = n_acc;
    chk("bp_latency", lat, 13);
    err_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) begin in = 8'h63; in_valid = 1'b1; end
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
      if (!out_valid || out != 8'hff || in_ready) err_cnt++;
    end
    chk("bp_hold_errors", err_cnt, 0);
    chk("bp_no_extra_accept", n_acc, acc0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_handshake", n_hs - hs0, 1);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    chk("bp_result", outs[outs.size()-1], 8'hff);

    // Asynchronous reset in the middle of a computation
    seen53 = 0;
    hs0 = n_hs;
    in = 8'hed; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    acc0 = n_acc;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out", out, 8'h00);
    chk("rst_mid_in_ready", in_ready, 1);
    in = 8'h00; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_mid_no_accept", n_acc, acc0);
    run_byte(8'h7c, 1'b1, r, lat);
    chk("rst_mid_out_7c", r, 8'h01);
    chk("rst_mid_latency", lat, 13);
    chk("rst_mid_one_result", n_hs - hs0, 1);
    chk("rst_mid_no_stale", seen53, 0);

    // Garbage on `in` while in_valid is low
    acc0 = n_acc;
    err_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      in = 8'($urandom);
      @(negedge clk);
      if (out_valid || !in_ready) err_cnt++;
    end
    chk("garbage_errors", err_cnt, 0);
    chk("garbage_no_accept", n_acc, acc0);
    run_byte(8'h00, 1'b1, r, lat);
    chk("garbage_then_00", r, 8'h52);

    // Back-to-back stream with in_valid and out_ready high
    b2b_in  = '{8'h63, 8'h16, 8'hed, 8'h7c};
    b2b_exp = '{8'h00, 8'hff, 8'h53, 8'h01};
    acc_cyc.delete();
    outs.delete();
    in = b2b_in[0];
    in_valid = 1'b1;
    for (int k = 0; k < 200 && outs.size() < 4; k++) begin
      @(negedge clk);
      if (acc_cyc.size() >= 4) in_valid = 1'b0;
      else if (in_ready) in = b2b_in[acc_cyc.size()];
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 4);
    chk("b2b_results", outs.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0 && k < acc_cyc.size())
        chk($sformatf("b2b_spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], 15);
      if (k < outs.size())
        chk($sformatf("b2b_out%0d", k), outs[k], b2b_exp[k]);
    end
    @(negedge clk);

    // Exhaustive sweep checked through the forward S-box
    hs0 = n_hs;
    outs.delete();
    bad_lat = 0;
    bad_inv = 0;
    for (int i = 0; i < 256; i++) begin
      run_byte(8'(i), 1'b1, r, lat);
      if (lat != 13) bad_lat++;
      if (fsbox(r) != 8'(i)) bad_inv++;
    end
    chk("sweep_count", n_hs - hs0, 256);
    chk("sweep_latency_errors", bad_lat, 0);
    chk("sweep_inverse_errors", bad_inv, 0);
    err_cnt = 0;
    for (int i = 0; i < outs.size(); i++)
      if (fsbox(outs[i]) != 8'(i)) err_cnt++;
    chk("sweep_order_errors", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
